// File: rtl/dense_mac_engine.sv
// dense_mac_engine: runtime-loadable fully-connected layer.
// One input element per cycle is broadcast to N_OUT parallel MAC lanes,
// followed by a round-half-up / saturate stage and a held output register.
// Optional build macro: DENSE_MAC_RELU_EN (clamp negative results to 0).
module dense_mac_engine #(
    parameter  int N_IN  = 32,
    parameter  int N_OUT = 5,
    parameter  int WIDTH = 21,
    parameter  int NFRAC = 10,
    localparam int ACC_W = 2*WIDTH + $clog2(N_IN) + 1,
    localparam int AW    = $clog2(N_IN*N_OUT + N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wt_we,
    input  logic [AW-1:0]          wt_addr,
    input  logic [WIDTH-1:0]       wt_data,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW = 2*WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic signed [ACC_W-1:0] SAT_MAX_A = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN_A = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] RND_HALF  = {{(ACC_W-NFRAC){1'b0}}, 1'b1, {(NFRAC-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]              r_state;
    logic [IW-1:0]           r_idx;
    logic signed [WIDTH-1:0] r_x [N_IN];
    logic signed [WIDTH-1:0] r_w [N_IN][N_OUT];
    logic signed [WIDTH-1:0] r_b [N_OUT];
    logic signed [WIDTH-1:0] w_bias [N_OUT];
    logic                    w_accept;
    logic                    w_last;
    logic                    w_wr_ok;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_last    = (r_idx == IW'(N_IN-1));
    assign w_wr_ok   = wt_we && (r_state == S_IDLE);
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_OUT);

    // Control FSM and element index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_state <= S_MAC;
                    r_idx   <= '0;
                end
                S_MAC: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) r_state <= S_FIN;
                end
                S_FIN:   r_state <= S_OUT;
                S_OUT:   if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Weight/bias memory; writes only land while idle, out-of-range addresses match nothing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++)
                for (int k = 0; k < N_OUT; k++)
                    r_w[i][k] <= '0;
            for (int k = 0; k < N_OUT; k++)
                r_b[k] <= '0;
        end else if (w_wr_ok) begin
            for (int i = 0; i < N_IN; i++)
                for (int k = 0; k < N_OUT; k++)
                    if (wt_addr == AW'(i*N_OUT + k)) r_w[i][k] <= wt_data;
            for (int k = 0; k < N_OUT; k++)
                if (wt_addr == AW'(N_IN*N_OUT + k)) r_b[k] <= wt_data;
        end
    end

    // Bias seen at accept: a bias write in the same idle cycle is forwarded so it takes effect
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            w_bias[k] = r_b[k];
            if (w_wr_ok && (wt_addr == AW'(N_IN*N_OUT + k))) w_bias[k] = wt_data;
        end
    end

    // Input vector capture on accept; the external bus is free afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) r_x[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < N_IN; i++) r_x[i] <= in_data[i*WIDTH +: WIDTH];
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        logic signed [PW-1:0]    w_prod;
        logic signed [ACC_W-1:0] w_rnd;
        logic signed [WIDTH-1:0] w_sat;
        logic signed [ACC_W-1:0] r_acc;
        logic signed [WIDTH-1:0] r_out;

        assign w_prod = PW'(r_x[r_idx]) * PW'(r_w[r_idx][k]);
        assign w_rnd  = (r_acc + RND_HALF) >>> NFRAC;

        // Accumulator: seeded with the aligned bias, then one product per MAC cycle
        always_ff @(posedge clk) begin
            if (!rst_n)
                r_acc <= '0;
            else if (w_accept)
                r_acc <= {{(ACC_W-WIDTH-NFRAC){w_bias[k][WIDTH-1]}}, w_bias[k], {NFRAC{1'b0}}};
            else if (r_state == S_MAC)
                r_acc <= r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
        end

        // Saturate the rounded value to the output word (and clamp negatives for hidden layers)
        always_comb begin
            w_sat = w_rnd[WIDTH-1:0];
            if (w_rnd > SAT_MAX_A)      w_sat = SAT_MAX;
            else if (w_rnd < SAT_MIN_A) w_sat = SAT_MIN;
`ifdef DENSE_MAC_RELU_EN
            if (w_sat[WIDTH-1]) w_sat = '0;
`endif
        end

        // Output register, loaded once in FIN and held through backpressure
        always_ff @(posedge clk) begin
            if (!rst_n)                r_out <= '0;
            else if (r_state == S_FIN) r_out <= w_sat;
        end

        assign out_data[k*WIDTH +: WIDTH] = r_out;
    end

endmodule

// File: tb/tb_dense_mac_engine.sv
// Self-checking bench for dense_mac_engine: directed table, randomized vectors
// against an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_dense_mac_engine;
    localparam int N_IN  = 32;
    localparam int N_OUT = 5;
    localparam int WIDTH = 21;
    localparam int NFRAC = 10;
    localparam int AW    = $clog2(N_IN*N_OUT + N_OUT);
    localparam int NW    = N_IN*N_OUT + N_OUT;
    localparam longint SMAX = (longint'(1) << (WIDTH-1)) - 1;
    localparam longint SMIN = -(longint'(1) << (WIDTH-1));

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   wt_we;
    logic [AW-1:0]          wt_addr;
    logic [WIDTH-1:0]       wt_data;
    logic                   busy;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_IN*WIDTH-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;

    dense_mac_engine dut (
        .clk(clk), .rst_n(rst_n), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]             mode;
        logic [N_OUT-1:0][31:0] exp;
    } vec_t;

    int mw [N_IN][N_OUT];
    int mb [N_OUT];
    int mx [N_IN];
    int got [N_OUT];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int nrn(input int k);
        logic signed [WIDTH-1:0] v;
        v = out_data[k*WIDTH +: WIDTH];
        return int'(v);
    endfunction

    // Reference: exact dot product plus scaled bias, round half up, clamp
    function automatic longint model(input int k);
        longint acc;
        acc = longint'(mb[k]) * (longint'(1) << NFRAC);
        for (int i = 0; i < N_IN; i++) acc += longint'(mx[i]) * longint'(mw[i][k]);
        acc = (acc + (longint'(1) << (NFRAC-1))) >>> NFRAC;
        if (acc > SMAX) acc = SMAX;
        if (acc < SMIN) acc = SMIN;
`ifdef DENSE_MAC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    function automatic int rnd_s(input int bits);
        return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits-1));
    endfunction

    function automatic vec_t mk(input int m, input int e0, input int e1, input int e2,
                                input int e3, input int e4);
        vec_t v;
        v.mode   = 8'(m);
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N_IN; i++) begin
            mx[i] = rnd_s(WIDTH);
            for (int k = 0; k < N_OUT; k++) mw[i][k] = 0;
        end
        for (int k = 0; k < N_OUT; k++) mb[k] = 0;
    endtask

    task automatic set_mode(input int m);
        clear_model();
        case (m)
            0: for (int k = 0; k < N_OUT; k++) mb[k] = k * 1024;
            1: for (int i = 0; i < N_IN; i++) begin
                   if (i < N_OUT) mw[i][i] = 1024;
                   mx[i] = (i + 1) * 512;
               end
            2: begin
                   for (int i = 0; i < N_IN; i++) begin
                       mx[i] = 1024;
                       for (int k = 0; k < N_OUT; k++) mw[i][k] = 1024;
                   end
                   for (int k = 0; k < N_OUT; k++) mb[k] = -64;
               end
            3: begin mw[0][0] = 512; mx[0] = 1; end
            4: for (int i = 0; i < N_IN; i++) begin mw[i][1] = 1048575;  mx[i] = 1048575; end
            5: for (int i = 0; i < N_IN; i++) begin mw[i][1] = -1048575; mx[i] = 1048575; end
            6: begin mw[0][0] = -512; mw[0][1] = -513; mw[0][2] = 1536; mx[0] = 1; end
            default: ;
        endcase
    endtask

    task automatic load_mem();
        for (int a = 0; a < NW; a++) begin
            @(negedge clk);
            wt_we   = 1'b1;
            wt_addr = AW'(a);
            wt_data = (a < N_IN*N_OUT) ? WIDTH'(mw[a / N_OUT][a % N_OUT])
                                       : WIDTH'(mb[a - N_IN*N_OUT]);
        end
        @(negedge clk);
        wt_we = 1'b0;
    endtask

    // Offer mx; optionally a weight write in the same cycle. Returns at the negedge after accept.
    task automatic start_vec(input bit wr, input int wa, input int wd);
        int n;
        @(negedge clk);
        for (int i = 0; i < N_IN; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(mx[i]);
        in_valid = 1'b1;
        if (wr) begin wt_we = 1'b1; wt_addr = AW'(wa); wt_data = WIDTH'(wd); end
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        wt_we    = 1'b0;
        for (int i = 0; i < N_IN; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("in_ready_after_accept", in_ready, 0);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
        for (int k = 0; k < N_OUT; k++) got[k] = nrn(k);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_hs", in_ready, 1);
        chk("out_valid_after_hs", out_valid, 0);
    endtask

    task automatic run_vec(input string nm);
        int lat;
        start_vec(1'b0, 0, 0);
        wait_out(lat);
        chk({nm, "_latency"}, lat, N_IN + 1);
        handshake();
    endtask

    vec_t vt [7];
    logic [N_OUT*WIDTH-1:0] saved;
    int lat;
    bit seen;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(0, 0, 1024, 2048, 3072, 4096);
        vt[1] = mk(1, 512, 1024, 1536, 2048, 2560);
        vt[2] = mk(2, 32704, 32704, 32704, 32704, 32704);
        vt[3] = mk(3, 1, 0, 0, 0, 0);
        vt[4] = mk(4, 0, 1048575, 0, 0, 0);
`ifdef DENSE_MAC_RELU_EN
        vt[5] = mk(5, 0, 0, 0, 0, 0);
        vt[6] = mk(6, 0, 0, 2, 0, 0);
`else
        vt[5] = mk(5, 0, -1048576, 0, 0, 0);
        vt[6] = mk(6, 0, -1, 2, 0, 0);
`endif

        rst_n = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data_zero", (out_data == '0), 1);
        rst_n = 1'b1;

        // Directed table
        for (int t = 0; t < 7; t++) begin
            set_mode(int'(vt[t].mode));
            load_mem();
            run_vec($sformatf("tbl%0d", t));
            for (int k = 0; k < N_OUT; k++)
                chk($sformatf("tbl%0d_n%0d", t, k), got[k], longint'($signed(vt[t].exp[k])));
        end

        // Randomized vectors against the reference model
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N_IN; i++) begin
                mx[i] = (r % 2) ? rnd_s(WIDTH) : rnd_s(15);
                for (int k = 0; k < N_OUT; k++) mw[i][k] = (r % 2) ? rnd_s(WIDTH) : rnd_s(12);
            end
            for (int k = 0; k < N_OUT; k++) mb[k] = (r % 2) ? rnd_s(WIDTH) : rnd_s(14);
            load_mem();
            run_vec($sformatf("rnd%0d", r));
            for (int k = 0; k < N_OUT; k++)
                chk($sformatf("rnd%0d_n%0d", r, k), got[k], model(k));
        end

        // Write while busy is dropped; write in the accept cycle takes effect
        clear_model();
        mx[0] = 1024;
        load_mem();
        start_vec(1'b0, 0, 0);
        @(negedge clk);
        chk("busy_during_wr", busy, 1);
        wt_we = 1'b1; wt_addr = '0; wt_data = WIDTH'(1024);
        @(negedge clk);
        wt_we = 1'b0;
        wait_out(lat);
        handshake();
        chk("busy_wr_dropped_n0", got[0], model(0));
        chk("busy_wr_dropped_zero", got[0], 0);
        mw[0][0] = 1024;
        for (int i = 1; i < N_IN; i++) mx[i] = rnd_s(WIDTH);
        start_vec(1'b1, 0, 1024);
        wait_out(lat);
        handshake();
        chk("idle_wr_n0", got[0], 1024);
        for (int k = 1; k < N_OUT; k++) chk($sformatf("idle_wr_n%0d", k), got[k], model(k));

        // Out-of-range addresses are ignored
        @(negedge clk);
        wt_we = 1'b1; wt_addr = AW'(NW); wt_data = WIDTH'(777);
        @(negedge clk);
        wt_addr = '1;
        @(negedge clk);
        wt_we = 1'b0;
        run_vec("oor");
        for (int k = 0; k < N_OUT; k++) chk($sformatf("oor_n%0d", k), got[k], model(k));

        // Backpressure: output held, no new accept
        set_mode(0);
        load_mem();
        out_ready = 1'b0;
        start_vec(1'b0, 0, 0);
        wait_out(lat);
        chk("bp_latency", lat, N_IN + 1);
        saved = out_data;
        in_valid = 1'b1;
        for (int i = 0; i < N_IN; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stable", (out_data == saved), 1);
        end
        in_valid = 1'b0;
        handshake();
        for (int k = 0; k < N_OUT; k++) chk($sformatf("bp_n%0d", k), got[k], k * 1024);

        // Reset in the middle of MAC (idx 15)
        set_mode(0);
        load_mem();
        start_vec(1'b0, 0, 0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data_zero", (out_data == '0), 1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mrst_no_out_valid", seen, 0);
        clear_model();
        run_vec("post_rst");
        for (int k = 0; k < N_OUT; k++) chk($sformatf("post_rst_n%0d", k), got[k], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_mac_engine.md
# dense_mac_engine

Parametrised, runtime-loadable fully-connected layer engine for the jet-tagging datapath. It computes N_OUT signed fixed-point dot products of an N_IN-element input vector against a weight/bias memory loaded through a write port, instead of baked-in constants. It sits between a batchnorm/activation stage and the next dense layer, with valid/ready handshakes on both sides. It time-multiplexes one input element per cycle across N_OUT parallel MACs.

## Interface
- N_IN, 32, input vector length
- N_OUT, 5, output neurons
- WIDTH, 21, signed word width for data, weights and bias
- NFRAC, 10, fractional bits for data, weights and bias
- ACC_W, 2*WIDTH+$clog2(N_IN)+1, accumulator width (derived, do not override)
- AW, $clog2(N_IN*N_OUT+N_OUT), weight-port address width (derived)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- wt_we  in  1  weight/bias write strobe
- wt_addr  in  AW  weight address i*N_OUT+k; bias address N_IN*N_OUT+k
- wt_data  in  WIDTH  signed value to write
- busy  out  1  high when state is not IDLE
- in_valid  in  1  input vector valid
- in_ready  out  1  engine can accept a vector
- in_data  in  N_IN*WIDTH  element i at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  N_OUT*WIDTH  neuron k at bits [k*WIDTH +: WIDTH]

## Operation
- FSM: IDLE -> MAC on in_valid && in_ready; MAC -> FIN after element N_IN-1; FIN -> OUT; OUT -> IDLE on out_valid && out_ready.
- IDLE: in_ready=1. On accept, capture in_data into an internal register and set acc[k] = bias[k] <<< NFRAC, sign-extended to ACC_W. Set idx=0.
- MAC, one cycle per idx 0..N_IN-1: acc[k] += x[idx]*w[idx][k], a full 2*WIDTH signed product, for all k in parallel.
- FIN: r = (acc + 2^(NFRAC-1)) >>> NFRAC, which is round half up. Then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and register into out_data.
- OUT: out_valid=1. out_data is held stable until the handshake.
- Weight writes apply only in IDLE. When wt_we is asserted with busy=1, the write is dropped with no other effect. Addresses >= N_IN*N_OUT+N_OUT are ignored.
- A write and an input accept in the same IDLE cycle: the write lands and the MAC uses the new value. The memory is read from MAC onwards.
- The external in_data may change after the accept cycle.

## Timing
- Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, out_data=0, all accumulators 0, all weights and biases 0.
- A reset asserted in any state takes effect at the next edge. An in-flight vector is discarded with no out_valid, and the weight memory clears.
- Accept at edge T. MAC runs edges T+1..T+N_IN. FIN is edge T+N_IN+1. out_valid=1 in the cycle after edge T+N_IN+1, i.e. latency N_IN+2 cycles.
- in_ready is 0 from the cycle after the accept until the cycle after the output handshake.
- Minimum period per vector is N_IN+3 cycles. There is no input/output overlap.
- out_valid does not depend combinationally on out_ready. in_ready is a registered state decode.

## Configuration
- DENSE_MAC_RELU_EN defined: after saturation, negative results are replaced by 0, so out_data is always >= 0. Used for hidden layers.
- Not defined: signed saturated result passed through unchanged. Used for the final logit layer.

## Test plan
- Bias only (defaults): all weights 0, bias[k]=k*1024, any input -> out_data neuron k = k*1024, out_valid in the cycle after edge T+N_IN+1.
- Identity: w[i][k]=1024 iff i==k, bias 0, x[i]=(i+1)*512 -> neuron k = (k+1)*512. Verify against the golden model: all 32x5 weights at 1.0, x all 1024, bias -64 -> each output 32704.
- Rounding/saturation: w[0][0]=512, x[0]=1 -> neuron 0 = 1. w[*][1]=1048575, x all 1048575 -> neuron 1 = 1048575. Negated weights -> -1048576, or 0 with DENSE_MAC_RELU_EN.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_data stable, in_ready=0, a new in_valid is not accepted. Release -> in_ready=1 in the next cycle.
- Write while busy: write w[0][0]=1024 during MAC -> dropped, result unchanged. The same write in IDLE -> takes effect on the next vector.
- Mid-operation reset: deassert rst_n for 1 cycle at idx=15 -> outputs and weights return to reset values, and no out_valid is produced for that vector.
